// File: rtl/multiport_regfile.sv
// multiport_regfile: NUM_RD-read / 1-write register file with registered reads,
// optional zero register and write-first bypass, and a DEPTH-cycle clear sequencer.
module multiport_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     clr_req,
  output logic                     busy
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;
  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        ptr_q, ptr_d;
  logic [NUM_RD*DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic                     wr_en, mem_we;
  logic [ADDR_W-1:0]        mem_wa;
  logic [DATA_W-1:0]        mem_wd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d   = ptr_q + 1'b1;
      state_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? RUN : CLEAR;
    end else if (clr_req) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end
  end
  always_comb busy = (state_q == CLEAR);
  // A clear request wins over a same-cycle write; entry 0 is never stored when hardwired.
  always_comb begin
    wr_en  = we && !busy && !clr_req && !(ZERO_REG != 0 && wa == '0);
    mem_we = busy || wr_en;
    mem_wa = busy ? ptr_q : wa;
    mem_wd = busy ? '0 : wd;
  end
  // Storage has no reset; the clear sequence zeroes it after every reset release.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end
  always_comb begin
    rd_d = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_d[k*DATA_W +: DATA_W] =
        (busy || (ZERO_REG != 0 && ra[k*ADDR_W +: ADDR_W] == '0)) ? '0 :
        (BYPASS != 0 && wr_en && wa == ra[k*ADDR_W +: ADDR_W])    ? wd :
        mem_q[ra[k*ADDR_W +: ADDR_W]];
    end
  end
  assign rd = rd_q;
endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile: directed + random stimulus against an array-based reference model.
module tb_multiport_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [9:0]  ra = '0;
  logic [63:0] rd;
  logic        clr_req = 1'b0;
  logic        busy;
  int          checks = 0;
  int          passes = 0;
  int          clr_left = 0;
  int          n;
  logic [31:0] mem_m [32];
  logic [31:0] exp0, exp1;
  logic [4:0]  a, r0;
  logic [31:0] d;

  multiport_regfile dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd), .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // Write-first reference read of the entry addressed by r, given the current inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] r);
    if (clr_left > 0 || r == 0) return '0;
    if (we && !clr_req && wa == r) return wd;
    return mem_m[r];
  endfunction

  task automatic step(input logic w, input logic [4:0] wa_i, input logic [31:0] wd_i,
                      input logic [4:0] ra0, input logic [4:0] ra1, input logic c);
    we = w; wa = wa_i; wd = wd_i; ra = {ra1, ra0}; clr_req = c;
    exp0 = exp_rd(ra0);
    exp1 = exp_rd(ra1);
    @(posedge clk);
    #1;
    if (clr_left > 0) clr_left--;
    else if (c) begin
      clr_left = 32;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (w && wa_i != 0) mem_m[wa_i] = wd_i;
    chk("rd0", rd[31:0], exp0);
    chk("rd1", rd[63:32], exp1);
    chk("busy", {31'b0, busy}, {31'b0, clr_left > 0});
    we = 1'b0; clr_req = 1'b0;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1, input logic c);
    step(1'b0, 5'd0, 32'd0, ra0, ra1, c);
  endtask

  task automatic count_clear(input int pulse_at);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      idle(5'(n), 5'(31 - n), n == pulse_at);
      n++;
    end
    chk("clear_len", n, 32);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rd0", rd[31:0], 32'd0);
    chk("rst_rd1", rd[63:32], 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    clr_left = 32;
    foreach (mem_m[i]) mem_m[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_clear(-1);
  endtask

  initial begin
    #3;
    do_reset();
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i), 1'b0);
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0);
    idle(5'd5, 5'd5, 1'b0);
    chk("rd0_deadbeef", rd[31:0], 32'hDEADBEEF);
    chk("rd1_deadbeef", rd[63:32], 32'hDEADBEEF);
    step(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd5, 1'b0);
    chk("bypass_7", rd[31:0], 32'h12345678);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
    chk("zero_bypass", rd[31:0], 32'd0);
    idle(5'd0, 5'd7, 1'b0);
    chk("zero_read", rd[31:0], 32'd0);
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 5'(i - 1), 5'(i), 1'b0);
    idle(5'd3, 5'd31, 1'b0);
    chk("pop3", rd[31:0], 32'h1000_0003);
    step(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3, 1'b1);
    chk("clr_read_old", rd[31:0], 32'h1000_0003);
    count_clear(10);
    idle(5'd3, 5'd3, 1'b0);
    chk("entry3_cleared", rd[31:0], 32'd0);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(i ^ 5'h1F), 1'b0);
    step(1'b1, 5'd9, 32'h55AA55AA, 5'd1, 5'd1, 1'b0);
    idle(5'd9, 5'd9, 1'b0);
    chk("pre_rst_rd", rd[31:0], 32'h55AA55AA);
    do_reset();
    idle(5'd9, 5'd9, 1'b0);
    idle(5'd1, 5'd2, 1'b1);
    repeat (15) idle(5'd4, 5'd5, 1'b0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a = 5'($urandom);
      d = $urandom;
      r0 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
      step(1'($urandom), a, d, r0, ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom),
           $urandom_range(0, 99) == 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL expose parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 The block SHALL expose parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-005 The block SHALL expose parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to matching reads.
REQ-006 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 The block SHALL have port we  input  1  write enable.
REQ-009 The block SHALL have port wa  input  ADDR_W  write address.
REQ-010 The block SHALL have port wd  input  DATA_W  write data.
REQ-011 The block SHALL have port ra  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 The block SHALL have port rd  output  NUM_RD*DATA_W  registered read data; port k at bits [k*DATA_W +: DATA_W].
REQ-013 The block SHALL have port clr_req  input  1  request to clear all entries to zero.
REQ-014 The block SHALL have port busy  output  1  high while the clear sequencer runs.

Function
REQ-015 Reads SHALL have 1-cycle latency: rd port k at edge n+1 reflects ra port k sampled at edge n.
REQ-016 Writes SHALL commit at the rising edge where we=1, busy=0, clr_req=0.
REQ-017 With ZERO_REG=1: writes to wa=0 dropped; ra=0 returns 0 regardless of bypass.
REQ-018 With BYPASS=1: if we=1, busy=0, clr_req=0, wa==ra[k] (and not the zero entry when ZERO_REG=1), rd[k] next cycle SHALL equal wd (write-first).
REQ-019 With BYPASS=0, the same collision SHALL return the pre-write contents (read-first).
REQ-020 All read ports SHALL operate independently; identical addresses on several ports return identical data.
REQ-021 Clear FSM SHALL have two states, CLEAR and RUN; busy = (state==CLEAR).
REQ-022 In CLEAR, each cycle SHALL write 0 to entry ptr and increment ptr; at ptr==DEPTH-1, next state RUN.
REQ-023 A full clear SHALL take exactly DEPTH cycles (busy high for DEPTH rising edges).
REQ-024 In RUN, clr_req=1 SHALL move to CLEAR with ptr=0 next cycle; a same-cycle we SHALL be dropped.
REQ-025 clr_req in CLEAR SHALL be ignored (no restart).
REQ-026 During CLEAR, we SHALL be ignored and every rd port SHALL register 0.
REQ-027 The first read sampled in RUN SHALL return array contents (0 unless written since clear).

Reset
REQ-028 rst_n low SHALL asynchronously force state=CLEAR, ptr=0, busy=1, all rd bits 0.
REQ-029 Array storage SHALL NOT be reset asynchronously; it is zeroed by the CLEAR sequence after rst_n release.
REQ-030 rst_n assertion mid-clear or mid-write SHALL abort the operation and restart the full DEPTH-cycle clear after release.

Verification
REQ-031 Release rst_n -> busy high exactly 32 cycles (defaults), then low; read all 32 entries -> all 0.
REQ-032 Write wa=5, wd=0xDEADBEEF; next cycle ra[0]=5 -> rd[0]=0xDEADBEEF one cycle later; ra[1]=5 same cycle -> rd[1] identical.
REQ-033 we=1, wa=7, wd=0x12345678 with ra[0]=7 same cycle -> rd[0]=0x12345678 (BYPASS=1) or prior value 0 (BYPASS=0).
REQ-034 Write wa=0, wd=0xFFFFFFFF, ZERO_REG=1 -> ra=0 returns 0, including same-cycle bypass case.
REQ-035 After populating entries, pulse clr_req with we=1, wa=3 -> busy high 32 cycles, entry 3 not written, all entries 0 afterwards; clr_req pulse at clear cycle 10 -> busy still drops after cycle 32.
REQ-036 Assert rst_n low at clear cycle 15 -> rd=0, busy=1 immediately; after release busy high a full 32 cycles.
